// File: rtl/vidmem_pkg.sv
// Shared constants and types for the video-memory arbiter and its address generator.
package vidmem_pkg;

    localparam logic [15:0] VBASE_DEF          = 16'h8000;
    localparam int          BYTES_PER_LINE_DEF = 80;

    // Phase of the 8-cycle byte period on which the display owns the RAM.
    localparam logic [2:0]  PHASE_VIDEO = 3'd0;

    // Decision-to-completion latency, shared by video and CPU slots.
    localparam int          CPU_LAT = 3;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_VIDEO = 2'd1,
        SLOT_CPU   = 2'd2
    } slot_e;

endpackage

// File: rtl/vidmem_arbiter_if.sv
// Bundle of the CPU, RAM and video-timing signals around vidmem_arbiter.
// slave = arbiter side, master = environment (CPU, RAM, video counters).
interface vidmem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              video_on;
    logic              video_vsync;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [7:0]        vid_data;
    logic              vid_strobe;

    modport slave (
        input  video_on, video_vsync, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, vid_data, vid_strobe
    );

    modport master (
        output video_on, video_vsync, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, vid_data, vid_strobe
    );

endinterface

// File: rtl/vidmem_addr_gen.sv
// Display fetch address generator: video_on edge detect, per-line base and running fetch address.
// VIDMEM_LINE_DOUBLE_EN: when defined, each framebuffer line is shown on two consecutive scanlines.
module vidmem_addr_gen
    import vidmem_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] VBASE          = ADDR_W'(VBASE_DEF),
    parameter int                BYTES_PER_LINE = BYTES_PER_LINE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_video_on,
    input  logic              i_video_vsync,
    input  logic              i_slot_video,
    output logic [ADDR_W-1:0] o_fetch_addr,
    output logic              o_line_start
);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(BYTES_PER_LINE);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic              r_video_on_d;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_vaddr;
    logic              w_line_end;

    assign o_line_start = i_video_on & ~r_video_on_d;
    assign w_line_end   = ~i_video_on & r_video_on_d;

    // The first slot of a line bypasses r_vaddr, which is only reloaded in that same cycle.
    assign o_fetch_addr = o_line_start ? r_line_base : r_vaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_video_on_d <= 1'b0;
            r_vaddr      <= VBASE;
        end else begin
            r_video_on_d <= i_video_on;
            if (o_line_start) begin
                r_vaddr <= r_line_base + ADDR_ONE;
            end else if (i_slot_video) begin
                r_vaddr <= r_vaddr + ADDR_ONE;
            end
        end
    end

`ifdef VIDMEM_LINE_DOUBLE_EN
    logic r_line_tgl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_base <= VBASE;
            r_line_tgl  <= 1'b0;
        end else if (!i_video_vsync) begin
            r_line_base <= VBASE;
            r_line_tgl  <= 1'b0;
        end else if (w_line_end) begin
            r_line_tgl <= ~r_line_tgl;
            if (r_line_tgl) begin
                r_line_base <= r_line_base + LINE_STEP;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_base <= VBASE;
        end else if (!i_video_vsync) begin
            r_line_base <= VBASE;
        end else if (w_line_end) begin
            r_line_base <= r_line_base + LINE_STEP;
        end
    end
`endif

endmodule

// File: rtl/vidmem_arbiter.sv
// Time-slot arbiter sharing one synchronous video RAM between display fetch and CPU.
// Build option VIDMEM_LINE_DOUBLE_EN (handled in vidmem_addr_gen) doubles every framebuffer line.
module vidmem_arbiter
    import vidmem_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] VBASE          = ADDR_W'(VBASE_DEF),
    parameter int                BYTES_PER_LINE = BYTES_PER_LINE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    vidmem_arbiter_if.slave bus
);

    logic [2:0]         r_phase;
    logic               r_cpu_busy;
    logic [CPU_LAT-2:0] r_vid_pipe;
    logic [CPU_LAT-2:0] r_cpu_pipe;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic [7:0]         r_mem_wdata;
    logic [7:0]         r_vid_data;
    logic               r_vid_strobe;
    logic [7:0]         r_cpu_rdata;
    logic               r_cpu_ack;

    logic [2:0]         w_phase;
    slot_e              w_slot;
    logic [ADDR_W-1:0]  w_fetch_addr;
    logic               w_line_start;

    vidmem_addr_gen #(
        .ADDR_W         (ADDR_W),
        .VBASE          (VBASE),
        .BYTES_PER_LINE (BYTES_PER_LINE)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .i_video_on    (bus.video_on),
        .i_video_vsync (bus.video_vsync),
        .i_slot_video  (w_slot == SLOT_VIDEO),
        .o_fetch_addr  (w_fetch_addr),
        .o_line_start  (w_line_start)
    );

    // Line start realigns the byte period so the first fetch happens on the edge itself.
    assign w_phase = w_line_start ? 3'd0 : r_phase;

    always_comb begin
        w_slot = SLOT_IDLE;
        if (bus.video_on && (w_phase == PHASE_VIDEO)) begin
            w_slot = SLOT_VIDEO;
        end else if (bus.cpu_req && !r_cpu_busy) begin
            w_slot = SLOT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= 3'd0;
            r_cpu_busy   <= 1'b0;
            r_vid_pipe   <= '0;
            r_cpu_pipe   <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 8'h00;
            r_vid_data   <= 8'h00;
            r_vid_strobe <= 1'b0;
            r_cpu_rdata  <= 8'h00;
            r_cpu_ack    <= 1'b0;
        end else begin
            r_phase    <= w_phase + 3'd1;
            r_vid_pipe <= {r_vid_pipe[CPU_LAT-3:0], w_slot == SLOT_VIDEO};
            r_cpu_pipe <= {r_cpu_pipe[CPU_LAT-3:0], w_slot == SLOT_CPU};
            r_mem_we   <= 1'b0;

            case (w_slot)
                SLOT_VIDEO: begin
                    r_mem_addr <= w_fetch_addr;
                end
                SLOT_CPU: begin
                    r_mem_addr  <= bus.cpu_addr;
                    r_mem_we    <= bus.cpu_we;
                    r_mem_wdata <= bus.cpu_wdata;
                end
                default: begin
                end
            endcase

            r_vid_strobe <= r_vid_pipe[CPU_LAT-2];
            if (r_vid_pipe[CPU_LAT-2]) begin
                r_vid_data <= bus.mem_rdata;
            end

            r_cpu_ack <= r_cpu_pipe[CPU_LAT-2];
            if (r_cpu_pipe[CPU_LAT-2]) begin
                r_cpu_rdata <= bus.mem_rdata;
            end

            // Busy stays set through the ack cycle so a still-high cpu_req is not re-decided.
            if (w_slot == SLOT_CPU) begin
                r_cpu_busy <= 1'b1;
            end else if (r_cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.vid_data   = r_vid_data;
    assign bus.vid_strobe = r_vid_strobe;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ack    = r_cpu_ack;

endmodule

// File: tb/tb_vidmem_arbiter.sv
// Self-checking bench for vidmem_arbiter: RAM model, video line driver and random CPU traffic
// checked against a slot-schedule model derived from video timing.
module tb_vidmem_arbiter;

    localparam int          ADDR_W = 16;
    localparam logic [15:0] VB     = 16'h8000;
    localparam int          BPL    = 80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vidmem_arbiter_if #(.ADDR_W(ADDR_W)) vif ();

    vidmem_arbiter #(
        .ADDR_W         (ADDR_W),
        .VBASE          (VB),
        .BYTES_PER_LINE (BPL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM device and the bench's own model of what memory should hold
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    function automatic logic [7:0] seed_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (vif.mem_we === 1'b1) ram[vif.mem_addr] <= vif.mem_wdata;
        vif.mem_rdata <= ram[vif.mem_addr];
    end

    // Expected display slots: decision cycle and the byte address it must fetch
    typedef struct {
        int          dec;
        logic [15:0] addr;
    } vslot_t;

    vslot_t vq[$];
    bit     vdec[int];
    int     strobes       = 0;
    int     lines_since_vs = 0;
    int     line_rise     = -1;

    always @(negedge clk) begin
        if (vq.size() > 0) begin
            if (cyc == vq[0].dec + 1) begin
                chk("vid_addr", vif.mem_addr, vq[0].addr);
                chk("vid_we", vif.mem_we, 0);
            end
        end
        if (vq.size() > 0 && cyc == vq[0].dec + 3) begin
            chk("vid_strobe", vif.vid_strobe, 1);
            chk("vid_data", vif.vid_data, ref_mem[vq[0].addr]);
            if (vif.vid_strobe === 1'b1) strobes++;
            void'(vq.pop_front());
        end else if (vif.vid_strobe === 1'b1) begin
            chk("vid_spurious", vif.vid_strobe, 0);
        end
    end

    task automatic run_line(input int blank, input bit vs_after);
        int          rise;
        int          s0;
        logic [15:0] base;
`ifdef VIDMEM_LINE_DOUBLE_EN
        base = VB + 16'(BPL * (lines_since_vs / 2));
`else
        base = VB + 16'(BPL * lines_since_vs);
`endif
        @(posedge clk); #1;
        vif.video_on = 1'b1;
        rise = cyc;
        s0   = strobes;
        for (int j = 0; j < BPL; j++) begin
            vq.push_back('{rise + 8 * j, base + 16'(j)});
            vdec[rise + 8 * j] = 1'b1;
        end
        line_rise = rise;
        repeat (640) @(posedge clk);
        #1;
        vif.video_on = 1'b0;
        lines_since_vs++;
        repeat (4) @(posedge clk);
        #1;
        chk("line_slots", strobes - s0, BPL);
        if (vs_after) begin
            vif.video_vsync = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            vif.video_vsync = 1'b1;
            lines_since_vs = 0;
        end
        repeat (blank) @(posedge clk);
    endtask

    task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                              input int at_cyc, output int lat);
        int t;
        int dec;
        int ack_cyc;
        bit got;
        do begin
            @(posedge clk); #1;
        end while (cyc < at_cyc);
        vif.cpu_req   = 1'b1;
        vif.cpu_we    = we;
        vif.cpu_addr  = addr;
        vif.cpu_wdata = wd;
        t = cyc;
        @(negedge clk);
        dec     = vdec.exists(t) ? t + 1 : t;
        got     = 1'b0;
        ack_cyc = -1;
        while (!got && cyc <= t + 12) begin
            if (cyc == dec + 1) begin
                chk("cpu_addr", vif.mem_addr, addr);
                chk("cpu_we", vif.mem_we, we);
                if (we) chk("cpu_wdata", vif.mem_wdata, wd);
            end
            if (cyc == dec + 2) chk("cpu_we_len", vif.mem_we, 0);
            if (vif.cpu_ack === 1'b1) begin
                got     = 1'b1;
                ack_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("cpu_ack_timeout", vif.cpu_ack, 1);
        end else begin
            chk("cpu_ack_cyc", ack_cyc, dec + 3);
            if (!we) chk("cpu_rdata", vif.cpu_rdata, ref_mem[addr]);
        end
        if (we) ref_mem[addr] = wd;
        lat = ack_cyc - t;
        @(posedge clk); #1;
        vif.cpu_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, vif.cpu_ack, 0);
        chk({tag, "_rdata"}, vif.cpu_rdata, 0);
        chk({tag, "_maddr"}, vif.mem_addr, 0);
        chk({tag, "_mwe"}, vif.mem_we, 0);
        chk({tag, "_mwdata"}, vif.mem_wdata, 0);
        chk({tag, "_vdata"}, vif.vid_data, 0);
        chk({tag, "_vstb"}, vif.vid_strobe, 0);
    endtask

    bit busy;

    initial begin
        int          lat;
        int          lat_coll;
        bit          r_we;
        logic [15:0] r_addr;
        logic [7:0]  r_data;

        for (int a = 0; a < 65536; a++) begin
            ram[a]     = seed_byte(16'(a));
            ref_mem[a] = seed_byte(16'(a));
        end
        rst             = 1'b1;
        vif.video_on    = 1'b0;
        vif.video_vsync = 1'b1;
        vif.cpu_req     = 1'b0;
        vif.cpu_we      = 1'b0;
        vif.cpu_addr    = '0;
        vif.cpu_wdata   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");

        // blanking write then read-back
        cpu_access(1'b1, 16'h0010, 8'hA5, 0, lat);
        chk("wr_lat", lat, 3);
        cpu_access(1'b0, 16'h0010, 8'h00, 0, lat);
        chk("rd_lat", lat, 3);

        // lines 0..2, vsync, then a collision on line 0 of the new frame
        run_line(30, 1'b0);
        run_line(30, 1'b0);
        run_line(30, 1'b1);
        line_rise = -1;
        fork
            run_line(30, 1'b0);
            begin
                wait (line_rise >= 0);
                cpu_access(1'b0, 16'h1234, 8'h00, line_rise + 16, lat_coll);
                chk("coll_lat", lat_coll, 4);
            end
        join

        // random CPU traffic against live video
        busy = 1'b1;
        fork
            begin
                run_line(40, 1'b0);
                run_line(25, 1'b1);
                run_line(50, 1'b0);
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    r_we   = 1'($urandom_range(0, 1));
                    r_addr = 16'($urandom_range(0, 63));
                    r_data = 8'($urandom);
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                    cpu_access(r_we, r_addr, r_data, 0, lat);
                end
            end
        join

        // reset during an outstanding read: no ack, bus idle afterwards
        repeat (3) @(posedge clk);
        #1;
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = 1'b0;
        vif.cpu_addr = 16'h0020;
        @(posedge clk); #1;
        rst         = 1'b1;
        vif.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vq.delete();
        lines_since_vs = 0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_ack", vif.cpu_ack, 0);
        end

        // frame restarts at VBASE after reset
        run_line(20, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
